// File: rtl/mc_pulse_train.sv
// Multi-channel RC-style pulse train generator: one slew-limited pulse per channel per frame,
// serialised onto PWM, with a per-frame command watchdog that forces all channels to neutral.
module mc_pulse_train #(
    parameter int NUM_CH         = 2,
    parameter int PWR_BITS       = 3,
    parameter int FRAME_CYC      = 1200000,
    parameter int NEUTRAL_CYC    = 150000,
    parameter int STEP_CYC       = 3125,
    parameter int GAP_CYC        = 110000,
    parameter int MAX_STEP       = 1,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_CH*(PWR_BITS+2)-1:0] CMD,
    input  logic                           CMD_VALID,
    output logic                           PWM,
    output logic                           FRAME_START,
    output logic                           TIMEOUT,
    output logic                           OVERRUN
);
    localparam int CW      = PWR_BITS + 2;
    localparam int CMD_W   = NUM_CH * CW;
    localparam int LVL_W   = PWR_BITS + 2;
    localparam int CNT_W   = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
    localparam int MAX_W   = NEUTRAL_CYC + (2 ** PWR_BITS) * STEP_CYC;
    localparam int TMR_MAX = (MAX_W > GAP_CYC) ? MAX_W : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W    = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
    localparam logic [CMD_W-1:0] CMD_NEUTRAL = {NUM_CH{{{PWR_BITS{1'b0}}, 2'b01}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    function automatic logic signed [LVL_W-1:0] decode_target(input logic [CW-1:0] c);
        logic signed [LVL_W-1:0] mag;
        mag = LVL_W'({2'b00, c[CW-1:2]}) + LVL_W'(1);
        case (c[1:0])
            2'b00:   decode_target = mag;
            2'b10:   decode_target = -mag;
            default: decode_target = '0;
        endcase
    endfunction

    function automatic logic signed [LVL_W-1:0] slew_to(input logic signed [LVL_W-1:0] lvl,
                                                        input logic signed [LVL_W-1:0] tgt);
        int diff;
        int nxt;
        diff = int'(tgt) - int'(lvl);
        if (diff > MAX_STEP) begin
            nxt = int'(lvl) + MAX_STEP;
        end else if (diff < -MAX_STEP) begin
            nxt = int'(lvl) - MAX_STEP;
        end else begin
            nxt = int'(tgt);
        end
        return LVL_W'(nxt);
    endfunction

    function automatic logic [TMR_W-1:0] pulse_cyc(input logic signed [LVL_W-1:0] lvl);
        return TMR_W'(NEUTRAL_CYC + int'(lvl) * STEP_CYC);
    endfunction

    logic [CNT_W-1:0]        frm_cnt_q, frm_cnt_d;
    state_e                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    pwm_q, pwm_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [CMD_W-1:0]        cmd_q, cmd_d;
    logic signed [LVL_W-1:0] lvl_q [NUM_CH];
    logic signed [LVL_W-1:0] lvl_d [NUM_CH];
    logic                    boundary_s, last_s, to_hit_s;
    logic [CH_W-1:0]         nxt_ch_s;

    assign boundary_s  = (frm_cnt_q == '0);
    assign last_s      = (frm_cnt_q == CNT_W'(FRAME_CYC - 1));
    assign nxt_ch_s    = ch_q + CH_W'(1);
    assign PWM         = pwm_q;
    assign TIMEOUT     = timeout_q;
    assign OVERRUN     = overrun_q;
    assign FRAME_START = boundary_s & ~RST;

    // Frame counter, command store, watchdog and per-frame level update.
    always_comb begin
        frm_cnt_d = last_s ? '0 : frm_cnt_q + CNT_W'(1);
        cmd_d     = cmd_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        lvl_d     = lvl_q;
        to_hit_s  = 1'b0;
        if (CMD_VALID) begin
            cmd_d = CMD;
        end else begin
            cmd_d = cmd_q;
        end
        if (boundary_s) begin
            if (CMD_VALID) begin
                wd_d      = '0;
                timeout_d = 1'b0;
            end else if (TIMEOUT_FRAMES > 0) begin
                if (int'(wd_q) + 1 >= TIMEOUT_FRAMES) begin
                    to_hit_s  = 1'b1;
                    wd_d      = WD_W'(TIMEOUT_FRAMES);
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end else begin
                wd_d = '0;
            end
            // While timed out the targets are held at zero; the stored command waits for CMD_VALID.
            for (int i = 0; i < NUM_CH; i++) begin
                if (to_hit_s) begin
                    lvl_d[i] = '0;
                end else begin
                    lvl_d[i] = slew_to(lvl_q[i],
                                       timeout_q ? '0 : decode_target(cmd_q[i*CW +: CW]));
                end
            end
        end else if (CMD_VALID) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end else begin
            wd_d = wd_q;
        end
    end

    // Pulse sequencer: next state, timer and the registered PWM/OVERRUN values.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tmr_d     = tmr_q;
        pwm_d     = 1'b0;
        overrun_d = 1'b0;
        if (boundary_s) begin
            state_d = ST_PULSE;
            ch_d    = '0;
            tmr_d   = pulse_cyc(lvl_d[0]) - TMR_W'(1);
            pwm_d   = 1'b1;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (tmr_q == '0) begin
                        state_d = ST_GAP;
                        tmr_d   = TMR_W'(GAP_CYC - 1);
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                        pwm_d = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end else if (int'(ch_q) == NUM_CH - 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PULSE;
                        ch_d    = nxt_ch_s;
                        tmr_d   = pulse_cyc(lvl_q[nxt_ch_s]) - TMR_W'(1);
                        pwm_d   = 1'b1;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // The boundary cycle itself is always low; flag a sequence still running into it.
        if (last_s) begin
            pwm_d     = 1'b0;
            overrun_d = (state_d != ST_IDLE);
        end else begin
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frm_cnt_q <= '0;
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            tmr_q     <= '0;
            pwm_q     <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            cmd_q     <= CMD_NEUTRAL;
            for (int i = 0; i < NUM_CH; i++) begin
                lvl_q[i] <= '0;
            end
        end else begin
            frm_cnt_q <= frm_cnt_d;
            state_q   <= state_d;
            ch_q      <= ch_d;
            tmr_q     <= tmr_d;
            pwm_q     <= pwm_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            cmd_q     <= cmd_d;
            for (int i = 0; i < NUM_CH; i++) begin
                lvl_q[i] <= lvl_d[i];
            end
        end
    end
endmodule

// File: tb/tb_mc_pulse_train.sv
// Self-checking bench for mc_pulse_train: frame-level reference model driven by directed and
// random command sequences, plus a short-frame instance for the overrun behaviour.
module tb_mc_pulse_train;
    localparam int NUM_CH         = 2;
    localparam int PWR_BITS       = 3;
    localparam int FRAME_CYC      = 200;
    localparam int NEUTRAL_CYC    = 30;
    localparam int STEP_CYC       = 3;
    localparam int GAP_CYC        = 10;
    localparam int MAX_STEP       = 2;
    localparam int TIMEOUT_FRAMES = 4;
    localparam int OV_FRAME       = 60;
    localparam int CW             = PWR_BITS + 2;
    localparam int CMD_W          = NUM_CH * CW;

    logic             clk = 1'b0;
    logic             rst, cmd_valid, pwm, frame_start, timeout, overrun;
    logic [CMD_W-1:0] cmd;
    logic             rst2, cmd_valid2, pwm2, frame_start2, timeout2, overrun2;
    logic [CMD_W-1:0] cmd2;

    always #5 clk = ~clk;

    mc_pulse_train #(
        .NUM_CH(NUM_CH), .PWR_BITS(PWR_BITS), .FRAME_CYC(FRAME_CYC), .NEUTRAL_CYC(NEUTRAL_CYC),
        .STEP_CYC(STEP_CYC), .GAP_CYC(GAP_CYC), .MAX_STEP(MAX_STEP), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) dut (
        .CLK(clk), .RST(rst), .CMD(cmd), .CMD_VALID(cmd_valid), .PWM(pwm),
        .FRAME_START(frame_start), .TIMEOUT(timeout), .OVERRUN(overrun)
    );

    mc_pulse_train #(
        .NUM_CH(NUM_CH), .PWR_BITS(PWR_BITS), .FRAME_CYC(OV_FRAME), .NEUTRAL_CYC(NEUTRAL_CYC),
        .STEP_CYC(STEP_CYC), .GAP_CYC(GAP_CYC), .MAX_STEP(MAX_STEP), .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) dut_ov (
        .CLK(clk), .RST(rst2), .CMD(cmd2), .CMD_VALID(cmd_valid2), .PWM(pwm2),
        .FRAME_START(frame_start2), .TIMEOUT(timeout2), .OVERRUN(overrun2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, in spec terms: applied levels, stored command, watchdog.
    int m_lvl [NUM_CH];
    int m_dir [NUM_CH];
    int m_pwr [NUM_CH];
    int m_wd;
    bit m_to;
    bit m_ovr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int target_of(input int dir, input int pwr);
        if (dir == 0) return pwr + 1;
        if (dir == 2) return -(pwr + 1);
        return 0;
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input int d0, input int p0, input int d1, input int p1);
        logic [CMD_W-1:0] v;
        v = '0;
        v[0 +: 2]             = 2'(d0);
        v[2 +: PWR_BITS]      = PWR_BITS'(p0);
        v[CW +: 2]            = 2'(d1);
        v[CW + 2 +: PWR_BITS] = PWR_BITS'(p1);
        return v;
    endfunction

    function automatic bit exp_pwm(input int t, input int w [NUM_CH]);
        int p;
        p = 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (t >= p && t < p + w[ch]) return 1'b1;
            p = p + w[ch] + GAP_CYC;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_lvl[ch] = 0;
            m_dir[ch] = 1;
            m_pwr[ch] = 0;
        end
        m_wd  = 0;
        m_to  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_store(input logic [CMD_W-1:0] c);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_dir[ch] = int'(c[ch*CW +: 2]);
            m_pwr[ch] = int'(c[ch*CW + 2 +: PWR_BITS]);
        end
    endtask

    task automatic model_boundary(input bit cv);
        bit hit;
        int d;
        hit = 1'b0;
        if (cv) begin
            m_wd = 0;
        end else if (TIMEOUT_FRAMES > 0) begin
            if (m_wd < TIMEOUT_FRAMES) m_wd++;
            hit = (m_wd >= TIMEOUT_FRAMES);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (hit) begin
                m_lvl[ch] = 0;
            end else begin
                d = (m_to ? 0 : target_of(m_dir[ch], m_pwr[ch])) - m_lvl[ch];
                if (d > MAX_STEP) d = MAX_STEP;
                if (d < -MAX_STEP) d = -MAX_STEP;
                m_lvl[ch] += d;
            end
        end
        m_to = cv ? 1'b0 : (hit ? 1'b1 : m_to);
    endtask

    // One full frame starting in the boundary cycle; optional command at offset off,
    // optional reset at offset rst_off (ends the frame early).
    task automatic run_frame(input bit send, input logic [CMD_W-1:0] c, input int off,
                             input int rst_off, input string tag);
        int w [NUM_CH];
        int mism, highs, exp_highs, fs_extra, sum;
        bit exp_ovr, e;
        mism = 0; highs = 0; exp_highs = 0; fs_extra = 0; sum = 0;
        exp_ovr = m_ovr;
        model_boundary(send && off == 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w[ch] = NEUTRAL_CYC + m_lvl[ch] * STEP_CYC;
            sum   += w[ch] + GAP_CYC;
        end
        m_ovr = (sum > FRAME_CYC - 1);
        if (send) begin
            model_store(c);
            m_wd = 0;
            m_to = 1'b0;
        end
        for (int t = 0; t < FRAME_CYC; t++) begin
            @(negedge clk);
            cmd_valid = send && (t == off);
            if (cmd_valid) cmd = c;
            if (t == rst_off) begin
                rst = 1'b1;
                cmd_valid = 1'b0;
                @(posedge clk);
                #1;
                check_val({tag, "_rst_pwm"}, 32'(pwm), 32'd0);
                check_val({tag, "_rst_timeout"}, 32'(timeout), 32'd0);
                rst = 1'b0;
                model_reset();
                return;
            end
            #1;
            e = exp_pwm(t, w);
            if (t == 0) begin
                check_val({tag, "_frame_start"}, 32'(frame_start), 32'd1);
                check_val({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
            end else if (frame_start !== 1'b0) begin
                fs_extra++;
            end
            if (pwm !== e) mism++;
            if (pwm === 1'b1) highs++;
            if (e) exp_highs++;
            if (t == FRAME_CYC - 1) check_val({tag, "_timeout"}, 32'(timeout), 32'(m_to));
        end
        check_val({tag, "_pwm_cycles_wrong"}, 32'(mism), 32'd0);
        check_val({tag, "_pwm_high_total"}, 32'(highs), 32'(exp_highs));
        check_val({tag, "_extra_frame_start"}, 32'(fs_extra), 32'd0);
    endtask

    initial begin
        logic [CMD_W-1:0] cmd_a, cmd_n;
        int w_ov [NUM_CH];
        int mism, high0, off;
        bit snd;
        cmd_a      = mk_cmd(0, 7, 2, 0);
        cmd_n      = mk_cmd(3, 0, 3, 0);
        rst        = 1'b1;
        rst2       = 1'b1;
        cmd        = mk_cmd(1, 0, 1, 0);
        cmd2       = mk_cmd(1, 0, 1, 0);
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_pwm", 32'(pwm), 32'd0);
        check_val("reset_frame_start", 32'(frame_start), 32'd0);
        check_val("reset_timeout", 32'(timeout), 32'd0);
        check_val("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        for (int f = 0; f < 6; f++) run_frame(1'b0, cmd_a, 0, -1, "idle");
        for (int f = 0; f < 6; f++) run_frame(1'b1, cmd_a, 50, -1, "ramp_up");
        for (int f = 0; f < 6; f++) run_frame(1'b1, cmd_n, 50, -1, "ramp_down");
        for (int f = 0; f < 5; f++) run_frame(1'b1, cmd_a, 70, -1, "ramp_again");
        for (int f = 0; f < 6; f++) run_frame(1'b0, cmd_a, 0, -1, "watchdog");
        for (int f = 0; f < 3; f++) run_frame(1'b1, cmd_a, 0, -1, "cmd_at_boundary");
        for (int f = 0; f < 25; f++) begin
            snd = ($urandom_range(0, 3) != 0);
            off = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, FRAME_CYC - 3));
            run_frame(snd, CMD_W'($urandom), off, -1, "random");
        end
        run_frame(1'b1, cmd_a, 40, -1, "pre_reset");
        run_frame(1'b0, cmd_a, 0, 10, "mid_reset");
        for (int f = 0; f < 2; f++) run_frame(1'b0, cmd_a, 0, -1, "post_reset");

        // Short-frame instance: every frame overruns during the ch1 pulse.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) w_ov[ch] = NEUTRAL_CYC;
        for (int f = 0; f < 6; f++) begin
            mism  = 0;
            high0 = 0;
            for (int t = 0; t < OV_FRAME; t++) begin
                @(negedge clk);
                #1;
                if (pwm2 !== exp_pwm(t, w_ov)) mism++;
                if (t <= NEUTRAL_CYC + 2 && pwm2 === 1'b1) high0++;
                if (t == 0) begin
                    check_val("ov_frame_start", 32'(frame_start2), 32'd1);
                    check_val("ov_overrun_strobe", 32'(overrun2), 32'(f > 0));
                    check_val("ov_pwm_at_boundary", 32'(pwm2), 32'd0);
                end
                if (t == 1) check_val("ov_overrun_one_cycle", 32'(overrun2), 32'd0);
                if (t == OV_FRAME - 1) check_val("ov_timeout", 32'(timeout2), 32'(f >= 3));
            end
            check_val("ov_pwm_cycles_wrong", 32'(mism), 32'd0);
            check_val("ov_ch0_width", 32'(high0), 32'(NEUTRAL_CYC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
